clock_divider_sequencer: RTL and testbench

Synthesizable, runtime-reprogrammable divide-by-N clock-enable generator with a glitch-free reconfiguration sequencer. A single requester programs the divisor, or gates the divided clock off and on, through a ready/valid port. Changes are applied only at a divided-clock period boundary, so downstream logic never sees a runt phase. The block sits in the clock/reset plumbing next to the fixed simulation dividers and drives clock-gate enables and divided-domain tick strobes.

---
 rtl/clock_divider_sequencer.sv | 175 +++++++++++++++++
 tb/tb_clock_divider_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_sequencer.sv
// Runtime-reprogrammable divide-by-N clock-enable generator. Divisor and gate
// changes requested over a ready/valid port are applied only at period boundaries.
module clock_divider_sequencer #(
  parameter int MAX_DIV   = 256,
  parameter int RESET_DIV = 1,
  parameter int DIV_W     = $clog2(MAX_DIV + 1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [DIV_W-1:0] req_div_i,
  input  logic             req_gate_i,
  output logic             done_o,
  output logic             err_o,
  output logic             clk_level_o,
  output logic             tick_o,
  output logic [DIV_W-1:0] cur_div_o,
  output logic             gated_o,
  output logic             bypass_o
);

  // Counter holds 0..MAX_DIV-1; sized from MAX_DIV so non-power-of-two limits still fit.
  localparam int CNT_W = $clog2(MAX_DIV);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_GATED = 2'd2;

  localparam logic [DIV_W-1:0] MAX_DIV_V   = DIV_W'(MAX_DIV);
  localparam logic [DIV_W-1:0] RESET_DIV_V = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);
  localparam logic             RESET_BYP   = (RESET_DIV == 1);

  logic [1:0]       state_q,    state_d;
  logic [DIV_W-1:0] cur_div_q,  cur_div_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [DIV_W-1:0] shd_div_q,  shd_div_d;
  logic             shd_gate_q, shd_gate_d;
  logic             done_q,     done_d;
  logic             err_q,      err_d;
  logic             ready_q,    ready_d;
  logic             level_q,    level_d;
  logic             tick_q,     tick_d;
  logic             gated_q,    gated_d;
  logic             bypass_q,   bypass_d;

  logic             accept;
  logic             req_legal;
  logic             at_boundary;
  logic [DIV_W-1:0] low_d;
  logic [DIV_W-1:0] count_d_ext;

  assign accept      = req_valid_i & ready_q;
  assign req_legal   = req_gate_i | ((req_div_i != '0) & (req_div_i <= MAX_DIV_V));
  assign at_boundary = (DIV_W'(count_q) == (cur_div_q - DIV_ONE));

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cur_div_d  = cur_div_q;
    shd_div_d  = shd_div_q;
    shd_gate_d = shd_gate_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (state_q == ST_GATED || at_boundary) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (!req_legal) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d    = ST_PEND;
            shd_div_d  = req_div_i;
            shd_gate_d = req_gate_i;
          end
        end
      end

      ST_PEND: begin
        // The accept cycle is never in PEND, so the first boundary seen here is >= accept+1.
        if (at_boundary) begin
          done_d  = 1'b1;
          count_d = '0;
          if (shd_gate_q) begin
            state_d = ST_GATED;
          end else begin
            state_d   = ST_RUN;
            cur_div_d = shd_div_q;
          end
        end
      end

      ST_GATED: begin
        if (accept) begin
          done_d = 1'b1;
          if (!req_legal) begin
            err_d = 1'b1;
          end else if (!req_gate_i) begin
            state_d   = ST_RUN;
            cur_div_d = req_div_i;
            count_d   = '0;
          end
        end
      end

      default: begin
        state_d = ST_RUN;
        count_d = '0;
      end
    endcase

    // Outputs are registered from next-state values so they line up with count_q.
    low_d       = cur_div_d >> 1;
    count_d_ext = DIV_W'(count_d);
    gated_d     = (state_d == ST_GATED);
    level_d     = !gated_d && (count_d_ext >= low_d);
    tick_d      = !gated_d && (count_d_ext == low_d);
    bypass_d    = (cur_div_d == DIV_ONE);
    ready_d     = (state_d != ST_PEND);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_RUN;
      cur_div_q <= RESET_DIV_V;
      count_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      level_q   <= RESET_BYP;
      tick_q    <= RESET_BYP;
      gated_q   <= 1'b0;
      bypass_q  <= RESET_BYP;
    end else begin
      state_q   <= state_d;
      cur_div_q <= cur_div_d;
      count_q   <= count_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      level_q   <= level_d;
      tick_q    <= tick_d;
      gated_q   <= gated_d;
      bypass_q  <= bypass_d;
    end
  end

  // NOTE: the shadow request is only read in PEND, which is always entered by
  // loading it, so it carries no reset.
  always_ff @(posedge clock_i) begin
    shd_div_q  <= shd_div_d;
    shd_gate_q <= shd_gate_d;
  end

  assign req_ready_o = ready_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign clk_level_o = level_q;
  assign tick_o      = tick_q;
  assign cur_div_o   = cur_div_q;
  assign gated_o     = gated_q;
  assign bypass_o    = bypass_q;

endmodule

// File: tb/tb_clock_divider_sequencer.sv
// Self-checking bench for clock_divider_sequencer: a cycle model of the divided clock,
// a scoreboard of expected done/err pulses, a request table and hand-built corner cases.
module tb_clock_divider_sequencer;

  localparam int MAX_DIV   = 256;
  localparam int RESET_DIV = 1;
  localparam int DIV_W     = $clog2(MAX_DIV + 1);

  logic             clock_i = 1'b0;
  logic             reset_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [DIV_W-1:0] req_div_i;
  logic             req_gate_i;
  logic             done_o;
  logic             err_o;
  logic             clk_level_o;
  logic             tick_o;
  logic [DIV_W-1:0] cur_div_o;
  logic             gated_o;
  logic             bypass_o;

  clock_divider_sequencer #(
    .MAX_DIV  (MAX_DIV),
    .RESET_DIV(RESET_DIV)
  ) dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_div_i  (req_div_i),
    .req_gate_i (req_gate_i),
    .done_o     (done_o),
    .err_o      (err_o),
    .clk_level_o(clk_level_o),
    .tick_o     (tick_o),
    .cur_div_o  (cur_div_o),
    .gated_o    (gated_o),
    .bypass_o   (bypass_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    int unsigned due;
    bit          err;
    bit          gate;
    int          div;
  } exp_t;

  typedef struct {
    bit gate;
    int div;
    bit exp_err;
    int exp_div;
    bit exp_gated;
  } vec_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;
  int unsigned last_accept = 0;
  bit          last_err = 1'b0;

  // Reference model of the architectural state, advanced once per clock.
  int m_div     = RESET_DIV;
  int m_count   = 0;
  bit m_gated   = 1'b0;
  bit m_pend    = 1'b0;
  bit m_rst_blk = 1'b1;
  bit m_live    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    bit   rst_s;
    bit   exp_done;
    bit   exp_err;
    exp_t e;
    rst_s    = reset_i;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    @(posedge clock_i);
    #1;
    cyc++;
    if (rst_s) begin
      m_div     = RESET_DIV;
      m_count   = 0;
      m_gated   = 1'b0;
      m_pend    = 1'b0;
      m_rst_blk = 1'b1;
      m_live    = 1'b1;
      sb_q.delete();
    end else if (m_live) begin
      m_rst_blk = 1'b0;
      m_count   = m_gated ? 0 : (m_count + 1) % m_div;
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        e        = sb_q.pop_front();
        exp_done = 1'b1;
        exp_err  = e.err;
        last_err = err_o;
        if (!e.err) begin
          if (e.gate) begin
            m_gated = 1'b1;
          end else begin
            m_div   = e.div;
            m_gated = 1'b0;
          end
          m_count = 0;
        end
        m_pend = 1'b0;
      end
    end
    if (m_live) begin
      check("done", done_o, exp_done);
      check("err", err_o, exp_err);
      check("clk_level", clk_level_o, m_gated ? 0 : (m_count >= m_div / 2));
      check("tick", tick_o, !m_gated && (m_count == m_div / 2));
      check("cur_div", cur_div_o, m_div);
      check("gated", gated_o, m_gated);
      check("bypass", bypass_o, m_div == 1);
      check("req_ready", req_ready_o, !m_rst_blk && !m_pend);
    end
  endtask

  // Issue one request in the current cycle and push its expected completion.
  task automatic send(input bit gate, input int div);
    int   guard;
    int   k;
    bit   legal;
    exp_t e;
    guard = 0;
    while ((m_rst_blk || m_pend) && guard < 600) begin
      step();
      guard++;
    end
    if (guard >= 600) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_wait at cycle %0d: ready never expected within budget", cyc);
    end
    req_valid_i = 1'b1;
    req_gate_i  = gate;
    req_div_i   = DIV_W'(div);
    legal       = gate || (div >= 1 && div <= MAX_DIV);
    e.err       = !legal;
    e.gate      = gate;
    e.div       = div;
    if (!legal || m_gated) begin
      e.due = cyc + 1;
    end else begin
      k      = (m_count < m_div - 1) ? (m_div - 1 - m_count) : m_div;
      e.due  = cyc + k + 1;
      m_pend = 1'b1;
    end
    sb_q.push_back(e);
    last_accept = cyc;
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (sb_q.size() > 0 && guard < 600) begin
      step();
      guard++;
    end
    if (guard >= 600) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_wait at cycle %0d: scoreboard not drained", cyc);
    end
  endtask

  vec_t vecs[13];

  initial begin
    logic [4:0] pat5;
    vecs[0]  = '{0, 0,       1, 5,   0};
    vecs[1]  = '{0, 257,     1, 5,   0};
    vecs[2]  = '{0, 4,       0, 4,   0};
    vecs[3]  = '{0, 3,       0, 3,   0};
    vecs[4]  = '{0, 6,       0, 6,   0};
    vecs[5]  = '{1, 0,       0, 6,   1};
    vecs[6]  = '{0, 0,       1, 6,   1};
    vecs[7]  = '{1, 77,      0, 6,   1};
    vecs[8]  = '{0, 2,       0, 2,   0};
    vecs[9]  = '{0, 2,       0, 2,   0};
    vecs[10] = '{0, MAX_DIV, 0, 256, 0};
    vecs[11] = '{0, 1,       0, 1,   0};
    vecs[12] = '{0, 7,       0, 7,   0};

    reset_i     = 1'b1;
    req_valid_i = 1'b0;
    req_gate_i  = 1'b0;
    req_div_i   = '0;

    // Reset held 8 cycles: divide-by-1 outputs, ready low.
    for (int i = 0; i < 8; i++) step();
    reset_i = 1'b0;
    step();
    step();
    check("ready_after_reset", req_ready_o, 1);

    // Divide-by-1 to divide-by-5: done two cycles after accept, then 0,0,1,1,1.
    send(0, 5);
    wait_idle();
    check("div5_latency", cyc - last_accept, 2);
    pat5 = 5'b11100;
    for (int i = 0; i < 10; i++) begin
      check("div5_level", clk_level_o, pat5[i % 5]);
      check("div5_tick", tick_o, (i % 5) == 2);
      step();
    end

    // Request table, with a varying idle gap to move the accept phase around.
    for (int i = 0; i < 13; i++) begin
      for (int j = 0; j < i % 3; j++) step();
      send(vecs[i].gate, vecs[i].div);
      wait_idle();
      check("vec_err", last_err, vecs[i].exp_err);
      check("vec_cur_div", cur_div_o, vecs[i].exp_div);
      check("vec_gated", gated_o, vecs[i].exp_gated);
    end

    // Divide-by-4, accept divide-by-3 at count 3: that boundary is skipped.
    send(0, 4);
    wait_idle();
    step();
    step();
    step();
    send(0, 3);
    wait_idle();
    check("skip_boundary_latency", cyc - last_accept, 5);
    for (int i = 0; i < 6; i++) step();

    // Gate at divide-by-6, then ungate straight into divide-by-2.
    send(0, 6);
    wait_idle();
    for (int i = 0; i < 2; i++) step();
    send(1, 0);
    wait_idle();
    check("gate_level", clk_level_o, 0);
    check("gate_flag", gated_o, 1);
    for (int i = 0; i < 3; i++) step();
    send(0, 2);
    wait_idle();
    check("ungate_latency", cyc - last_accept, 1);
    for (int i = 0; i < 6; i++) begin
      check("div2_level", clk_level_o, i % 2);
      step();
    end

    // Reset while a request is pending: no done, divisor back to reset value.
    send(0, 8);
    wait_idle();
    send(0, 3);
    step();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    step();
    check("pend_reset_div", cur_div_o, RESET_DIV);
    check("pend_reset_ready", req_ready_o, 1);
    send(0, 5);
    wait_idle();
    check("post_reset_div", cur_div_o, 5);
    for (int i = 0; i < 20; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
